// File: rtl/exposure_pkg.sv
// Shared definitions for the UV exposure sequencer.
//   - state_t : top-level sequencer states
//   - wr_t    : progress of one digipot write handshake
//   - MAX_*   : clamp limits applied when settings are snapshotted
//   - CNT_W   : width of every ms / repetition count
//   - clamp_cnt(): limits a count to a maximum
package exposure_pkg;

  localparam int CNT_W    = 14;
  localparam int MAX_MS   = 9999;
  localparam int MAX_REPS = 9999;
  localparam int MAX_INT  = 100;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_ARMED,
    ST_LOAD_ON,
    ST_ON,
    ST_LOAD_OFF,
    ST_OFF,
    ST_DONE,
    ST_SHUTDOWN,
    ST_FAULT
  } state_t;

  // WR_REQ : waiting for i2c_ready before strobing
  // WR_LOW : strobe issued, waiting for the controller to go busy
  // WR_HIGH: waiting for the controller to become ready again
  typedef enum logic [1:0] {
    WR_REQ,
    WR_LOW,
    WR_HIGH
  } wr_t;

  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler for the phase timer.
//   clk     in  system clock
//   rst     in  asynchronous reset, active-high
//   restart in  forces the count back to zero on the next edge, so the
//               first tick lands TICK_DIV clocks after the restart cycle
//   tick    out high for one clock every TICK_DIV clocks
module ms_tick_gen #(
  parameter int TICK_DIV = 16_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("TICK_DIV must be at least 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Tick is never needed on the restart cycle (that cycle is always in a
  // LOAD state), so it is kept purely registered-count based.
  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/exposure_sequencer.sv
// UV exposure sequencer: runs N repetitions of an ON phase followed by an
// OFF phase, writing the digipot (intensity at ON start, 0 at OFF start)
// through i2c_controller and gating the UV LED driver during ON.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   arm, fire, abort     front-panel control (arm level, fire/abort pulses)
//   on_ms, off_ms, reps  phase durations (ms) and repetition count
//   intensity            ON-phase digipot code
//   i2c_ready            i2c_controller idle/ready
//   i2c_data/i2c_enable  digipot byte and one-cycle write strobe
//   led_gate             UV driver enable, high only during ON
//   busy, phase_on       run status
//   elapsed_ms           ms elapsed in the current phase
//   rep_count            completed repetitions
//   done                 one-cycle pulse on normal completion
//   fault                sticky i2c timeout flag
//
// Build option: define SEQ_I2C_WATCHDOG_EN to bound every i2c wait by
// I2C_TIMEOUT clocks; a longer wait parks the sequencer in FAULT until
// reset. Without it, i2c waits are unbounded and fault is tied low.
module exposure_sequencer #(
  parameter int CLK_HZ      = 16_000_000,
  parameter int TICK_DIV    = CLK_HZ / 1000,
  parameter int MAX_MS      = exposure_pkg::MAX_MS,
  parameter int MAX_REPS    = exposure_pkg::MAX_REPS,
  parameter int MAX_INT     = exposure_pkg::MAX_INT,
  parameter int I2C_TIMEOUT = 160_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        fire,
  input  logic        abort,
  input  logic [13:0] on_ms,
  input  logic [13:0] off_ms,
  input  logic [13:0] reps,
  input  logic [6:0]  intensity,
  input  logic        i2c_ready,
  output logic [7:0]  i2c_data,
  output logic        i2c_enable,
  output logic        led_gate,
  output logic        busy,
  output logic        phase_on,
  output logic [13:0] elapsed_ms,
  output logic [13:0] rep_count,
  output logic        done,
  output logic        fault
);

  import exposure_pkg::*;

  if (I2C_TIMEOUT < 1) begin : g_bad_timeout
    $error("I2C_TIMEOUT must be at least 1");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] max_v);
    return (v >= max_v) ? max_v : v + 1'b1;
  endfunction

  state_t           state_q, state_d;
  wr_t              wr_q, wr_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] on_snap_q, on_snap_d;
  logic [CNT_W-1:0] off_snap_q, off_snap_d;
  logic [CNT_W-1:0] reps_snap_q, reps_snap_d;
  logic [6:0]       int_snap_q, int_snap_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [7:0]       i2c_data_q, i2c_data_d;
  logic             i2c_enable_q, i2c_enable_d;
  logic             led_gate_q, led_gate_d;
  logic             busy_q, busy_d;
  logic             phase_on_q, phase_on_d;
  logic             done_q, done_d;

`ifdef SEQ_I2C_WATCHDOG_EN
  localparam int WD_W = $clog2(I2C_TIMEOUT + 1);
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             fault_q, fault_d;
`endif

  logic             in_write;
  logic             wr_adv;
  logic             wr_done;
  logic             stop;
  logic             restart;
  logic             tick;
  logic [7:0]       wr_val;
  logic [CNT_W-1:0] ms_next;
  logic [CNT_W-1:0] rep_next;

  ms_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  assign in_write = (state_q == ST_INIT) || (state_q == ST_LOAD_ON) ||
                    (state_q == ST_LOAD_OFF) || (state_q == ST_SHUTDOWN);
  // arm can only be low inside a run if it fell after fire.
  assign stop     = abort || !arm;
  assign wr_val   = (state_q == ST_LOAD_ON) ? {1'b0, int_snap_q} : 8'd0;
  assign ms_next  = sat_inc(elapsed_q, CNT_W'(MAX_MS));
  assign rep_next = sat_inc(rep_q, CNT_W'(MAX_REPS));

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    pend_d       = pend_q;
    on_snap_d    = on_snap_q;
    off_snap_d   = off_snap_q;
    reps_snap_d  = reps_snap_q;
    int_snap_d   = int_snap_q;
    elapsed_d    = elapsed_q;
    rep_d        = rep_q;
    i2c_data_d   = i2c_data_q;
    i2c_enable_d = 1'b0;
    wr_adv       = 1'b0;
    wr_done      = 1'b0;
    restart      = 1'b0;
`ifdef SEQ_I2C_WATCHDOG_EN
    wd_d         = '0;
`endif

    // Digipot write handshake, shared by every write state.
    if (in_write) begin
      case (wr_q)
        WR_REQ: if (i2c_ready) begin
          i2c_enable_d = 1'b1;
          i2c_data_d   = wr_val;
          wr_d         = WR_LOW;
          wr_adv       = 1'b1;
        end
        WR_LOW: if (!i2c_ready) begin
          wr_d   = WR_HIGH;
          wr_adv = 1'b1;
        end
        WR_HIGH: if (i2c_ready) begin
          wr_d    = WR_REQ;
          wr_done = 1'b1;
          wr_adv  = 1'b1;
        end
        default: wr_d = WR_REQ;
      endcase
    end

    case (state_q)
      ST_INIT: if (wr_done) state_d = ST_IDLE;
      ST_IDLE: if (arm) state_d = ST_ARMED;
      ST_ARMED: begin
        if (!arm) begin
          state_d = ST_IDLE;
        end else if (fire) begin
          state_d     = ST_LOAD_ON;
          on_snap_d   = clamp_cnt(on_ms, CNT_W'(MAX_MS));
          off_snap_d  = clamp_cnt(off_ms, CNT_W'(MAX_MS));
          reps_snap_d = (reps == '0) ? CNT_W'(1) : clamp_cnt(reps, CNT_W'(MAX_REPS));
          int_snap_d  = 7'(clamp_cnt(CNT_W'(intensity), CNT_W'(MAX_INT)));
          rep_d       = '0;
          elapsed_d   = '0;
        end
      end
      ST_LOAD_ON, ST_LOAD_OFF: begin
        if (stop) begin
          // A strobe already issued (or issued this cycle) must finish
          // before the shutdown write can start.
          state_d = ST_SHUTDOWN;
          pend_d  = (wr_d != WR_REQ);
        end else if (wr_done) begin
          state_d   = (state_q == ST_LOAD_ON) ? ST_ON : ST_OFF;
          elapsed_d = '0;
          restart   = 1'b1;
        end
      end
      ST_ON: begin
        if (stop) begin
          state_d = ST_SHUTDOWN;
          pend_d  = 1'b0;
        end else begin
          if (tick) elapsed_d = ms_next;
          if ((on_snap_q == '0) || (tick && (ms_next >= on_snap_q))) begin
            state_d = ST_LOAD_OFF;
          end
        end
      end
      ST_OFF: begin
        if (stop) begin
          state_d = ST_SHUTDOWN;
          pend_d  = 1'b0;
        end else begin
          if (tick) elapsed_d = ms_next;
          if ((off_snap_q == '0) || (tick && (ms_next >= off_snap_q))) begin
            rep_d   = rep_next;
            state_d = (rep_next >= reps_snap_q) ? ST_DONE : ST_LOAD_ON;
          end
        end
      end
      ST_DONE: state_d = arm ? ST_ARMED : ST_IDLE;
      ST_SHUTDOWN: begin
        if (wr_done) begin
          if (pend_q) begin
            pend_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default: state_d = ST_INIT;
    endcase

`ifdef SEQ_I2C_WATCHDOG_EN
    // wd_q counts consecutive stalled cycles already spent in the current
    // wait; one more stalled cycle beyond I2C_TIMEOUT is a fault.
    if (in_write && !wr_adv) begin
      if (wd_q >= WD_W'(I2C_TIMEOUT)) begin
        state_d      = ST_FAULT;
        wr_d         = WR_REQ;
        pend_d       = 1'b0;
        wd_d         = '0;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
    fault_d = (state_d == ST_FAULT);
`endif

    led_gate_d = (state_d == ST_ON) && (on_snap_q != '0);
    phase_on_d = (state_d == ST_ON);
    busy_d     = !((state_d == ST_IDLE) || (state_d == ST_ARMED));
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      wr_q         <= WR_REQ;
      pend_q       <= 1'b0;
      on_snap_q    <= '0;
      off_snap_q   <= '0;
      reps_snap_q  <= '0;
      int_snap_q   <= '0;
      elapsed_q    <= '0;
      rep_q        <= '0;
      i2c_data_q   <= '0;
      i2c_enable_q <= 1'b0;
      led_gate_q   <= 1'b0;
      busy_q       <= 1'b0;
      phase_on_q   <= 1'b0;
      done_q       <= 1'b0;
`ifdef SEQ_I2C_WATCHDOG_EN
      wd_q         <= '0;
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      pend_q       <= pend_d;
      on_snap_q    <= on_snap_d;
      off_snap_q   <= off_snap_d;
      reps_snap_q  <= reps_snap_d;
      int_snap_q   <= int_snap_d;
      elapsed_q    <= elapsed_d;
      rep_q        <= rep_d;
      i2c_data_q   <= i2c_data_d;
      i2c_enable_q <= i2c_enable_d;
      led_gate_q   <= led_gate_d;
      busy_q       <= busy_d;
      phase_on_q   <= phase_on_d;
      done_q       <= done_d;
`ifdef SEQ_I2C_WATCHDOG_EN
      wd_q         <= wd_d;
      fault_q      <= fault_d;
`endif
    end
  end

  assign i2c_data   = i2c_data_q;
  assign i2c_enable = i2c_enable_q;
  assign led_gate   = led_gate_q;
  assign busy       = busy_q;
  assign phase_on   = phase_on_q;
  assign elapsed_ms = elapsed_q;
  assign rep_count  = rep_q;
  assign done       = done_q;
`ifdef SEQ_I2C_WATCHDOG_EN
  assign fault      = fault_q;
`else
  assign fault      = 1'b0;
`endif

endmodule

// File: tb/tb_exposure_sequencer.sv
// Bench for exposure_sequencer: directed and randomized exposure runs
// against an i2c_controller stand-in with random busy latency, checked
// against expectations computed from the sequencing rules.
module tb_exposure_sequencer;

  localparam int TD = 4;
  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst, arm, fire, abort;
  logic [13:0] on_ms, off_ms, reps;
  logic [6:0]  intensity;
  logic        i2c_ready = 1'b1;
  logic [7:0]  i2c_data;
  logic        i2c_enable, led_gate, busy, phase_on, done, fault;
  logic [13:0] elapsed_ms, rep_count;

  always #5 clk = ~clk;

  exposure_sequencer #(
    .CLK_HZ      (4000),
    .TICK_DIV    (TD),
    .I2C_TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .fire       (fire),
    .abort      (abort),
    .on_ms      (on_ms),
    .off_ms     (off_ms),
    .reps       (reps),
    .intensity  (intensity),
    .i2c_ready  (i2c_ready),
    .i2c_data   (i2c_data),
    .i2c_enable (i2c_enable),
    .led_gate   (led_gate),
    .busy       (busy),
    .phase_on   (phase_on),
    .elapsed_ms (elapsed_ms),
    .rep_count  (rep_count),
    .done       (done),
    .fault      (fault)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] writes[$];
  int         runs[$];
  int         done_cnt = 0;
  int         run_len  = 0;
  int         dbl_err  = 0;
  int         gate_bad = 0;
  int         lat      = 0;
  bit         hold_low = 1'b0;
  logic       en_prev  = 1'b0;

  // i2c_controller stand-in plus output monitors, all sampled on negedge.
  always @(negedge clk) begin
    if (rst) begin
      i2c_ready = 1'b1;
      en_prev   = 1'b0;
      run_len   = 0;
    end else begin
      if (i2c_enable) begin
        writes.push_back(i2c_data);
        if (en_prev) dbl_err++;
      end
      en_prev = i2c_enable;
      if (hold_low) begin
        i2c_ready = 1'b0;
      end else if (i2c_enable) begin
        i2c_ready = 1'b0;
        lat = $urandom_range(1, 3);
      end else if (!i2c_ready) begin
        if (lat > 1) lat--;
        else i2c_ready = 1'b1;
      end
      if (done) done_cnt++;
      if (led_gate && !phase_on) gate_bad++;
      if (led_gate) run_len++;
      else if (run_len > 0) begin
        runs.push_back(run_len);
        run_len = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    writes.delete();
    runs.delete();
    done_cnt = 0;
  endtask

  task automatic wait_busy(input logic level, input int budget, input string tag);
    int n = 0;
    while (busy !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, busy}, {31'd0, level});
  endtask

  task automatic pulse_fire();
    fire = 1'b1;
    @(negedge clk);
    fire = 1'b0;
  endtask

  // Full run; optionally disturbs the inputs mid-run, which must be ignored.
  task automatic run_check(input int on, input int off, input int rp, input int inten,
                           input bit disturb, input string tag);
    int reff, ieff, budget;
    logic [7:0] exp_w[$];
    int exp_r[$];
    reff = (rp == 0) ? 1 : ((rp > 9999) ? 9999 : rp);
    ieff = (inten > 100) ? 100 : inten;
    for (int r = 0; r < reff; r++) begin
      exp_w.push_back(8'(ieff));
      exp_w.push_back(8'd0);
      if (on > 0) exp_r.push_back(on * TD);
    end
    budget = reff * ((on + off) * TD + 40) + 60;
    on_ms = 14'(on); off_ms = 14'(off); reps = 14'(rp); intensity = 7'(inten);
    arm = 1'b1;
    repeat (3) @(negedge clk);
    clear_mon();
    pulse_fire();
    wait_busy(1'b1, 5, {tag, "_start"});
    if (disturb) begin
      repeat (6) @(negedge clk);
      on_ms = 14'(on + 5); off_ms = 14'(off + 3); reps = 14'(rp + 2); intensity = 7'd55;
      pulse_fire();
    end
    wait_busy(1'b0, budget, {tag, "_end"});
    chk({tag, "_nwr"}, writes.size(), exp_w.size());
    if (writes.size() == exp_w.size())
      foreach (exp_w[i]) chk({tag, "_wr"}, {24'd0, writes[i]}, {24'd0, exp_w[i]});
    chk({tag, "_nrun"}, runs.size(), exp_r.size());
    if (runs.size() == exp_r.size())
      foreach (exp_r[i]) chk({tag, "_ledlen"}, runs[i], exp_r[i]);
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_reps"}, {18'd0, rep_count}, reff);
  endtask

  initial begin
    int n;
    rst = 1'b1; arm = 1'b0; fire = 1'b0; abort = 1'b0;
    on_ms = '0; off_ms = '0; reps = '0; intensity = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {i2c_enable, led_gate, busy, phase_on, done, fault, 2'b0},
        8'd0);
    chk("rst_data", {24'd0, i2c_data}, 0);
    chk("rst_cnts", {4'd0, elapsed_ms, rep_count}, 0);

    // Reset release: one write of 0 from INIT, then idle.
    rst = 1'b0;
    n = 0;
    while (writes.size() == 0 && n < 50) begin @(negedge clk); n++; end
    wait_busy(1'b0, 50, "init_idle");
    chk("init_nwr", writes.size(), 1);
    if (writes.size() > 0) chk("init_wr", {24'd0, writes[0]}, 0);
    chk("init_led", {31'd0, led_gate}, 0);
    chk("init_done", done_cnt, 0);

    run_check(3, 2, 2, 10, 1'b0, "basic");
    run_check(1, 1, 0, 120, 1'b0, "clamp");
    run_check(2, 1, 2, 40, 1'b1, "disturb");
    run_check(0, 0, 2, 7, 1'b0, "zero_ms");
    for (int k = 0; k < 6; k++)
      run_check($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                $urandom_range(0, 127), 1'(k % 2), "rand");

    // Abort in the middle of ON.
    on_ms = 14'd3; off_ms = 14'd2; reps = 14'd2; intensity = 7'd20;
    repeat (3) @(negedge clk);
    clear_mon();
    pulse_fire();
    n = 0;
    while (!led_gate && n < 100) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk("abort_pre_led", {31'd0, led_gate}, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_led", {31'd0, led_gate}, 0);
    wait_busy(1'b0, 100, "abort_end");
    chk("abort_nwr", writes.size(), 2);
    if (writes.size() == 2) chk("abort_wr", {24'd0, writes[1]}, 0);
    chk("abort_done", done_cnt, 0);
    chk("abort_reps", {18'd0, rep_count}, 0);

    // arm dropped while the OFF write handshake is still pending.
    on_ms = 14'd1; off_ms = 14'd1; reps = 14'd3; intensity = 7'd33;
    repeat (3) @(negedge clk);
    clear_mon();
    pulse_fire();
    n = 0;
    while (!(i2c_enable && i2c_data == 8'd0) && n < 100) begin @(negedge clk); n++; end
    arm = 1'b0;
    wait_busy(1'b0, 100, "disarm_end");
    repeat (2) @(negedge clk);
    chk("disarm_nwr", writes.size(), 3);
    if (writes.size() == 3) begin
      chk("disarm_wr0", {24'd0, writes[0]}, 33);
      chk("disarm_wr2", {24'd0, writes[2]}, 0);
    end
    chk("disarm_done", done_cnt, 0);
    chk("disarm_led", {31'd0, led_gate}, 0);

    chk("enable_width", dbl_err, 0);
    chk("gate_in_on", gate_bad, 0);

`ifdef SEQ_I2C_WATCHDOG_EN
    arm = 1'b1;
    repeat (3) @(negedge clk);
    hold_low = 1'b1;
    pulse_fire();
    repeat (TO + 10) @(negedge clk);
    chk("wd_fault", {31'd0, fault}, 1);
    chk("wd_led", {31'd0, led_gate}, 0);
    chk("wd_busy", {31'd0, busy}, 1);
    hold_low = 1'b0;
    repeat (20) @(negedge clk);
    chk("wd_sticky", {31'd0, fault}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("wd_rst", {31'd0, fault}, 0);
`else
    chk("no_fault", {31'd0, fault}, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
